// File: rtl/sfm_pkg.sv
// Shared types and helpers for the TCDM responder: default response word and byte-offset width.
package sfm_pkg;

  localparam int unsigned SFM_DATA_WIDTH = 128;

  typedef logic [SFM_DATA_WIDTH-1:0] resp_entry_t;

  localparam int unsigned SFM_BYTE_OFF_W = $clog2(SFM_DATA_WIDTH / 8);

  // Number of address bits that select a byte inside one data word.
  function automatic int unsigned byte_off_w(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/sfm_tcdm_resp_fifo.sv
// Read-response FIFO for the TCDM responder; circular buffer with synchronous flush.
module sfm_tcdm_resp_fifo
  import sfm_pkg::*;
#(
  parameter int unsigned WIDTH = SFM_DATA_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) store_q[wr_ptr_q] <= wdata;
  end

  assign rdata = store_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/sfm_tcdm_responder.sv
// TCDM slave model: byte-enabled word memory with in-order read-response FIFO.
// Optional grant stalling every STALL_PERIOD cycles is enabled by defining SFM_TCDM_RESP_STALL_EN.
module sfm_tcdm_responder
  import sfm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned RESP_DEPTH   = 4,
  parameter int unsigned STALL_PERIOD = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  output logic                    err_o,
  input  logic                    tcdm_req,
  output logic                    tcdm_gnt,
  input  logic [ADDR_WIDTH-1:0]   tcdm_add,
  input  logic                    tcdm_wen,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be,
  input  logic [DATA_WIDTH-1:0]   tcdm_data,
  output logic [DATA_WIDTH-1:0]   tcdm_r_data,
  output logic                    tcdm_r_valid,
  input  logic                    tcdm_r_ready
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = byte_off_w(DATA_WIDTH);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic [IDX_W-1:0]      idx;
  logic                  oor;
  logic                  stall;
  logic                  rd_ok;
  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  err_q;
  logic                  unused_add_bits;

  assign idx             = tcdm_add[OFF_W +: IDX_W];
  assign unused_add_bits = ^tcdm_add[OFF_W-1:0];

  // Memory size is a power of two, so out-of-range is any set bit above the word index.
  generate
    if (ADDR_WIDTH > OFF_W + IDX_W) begin : g_oor
      assign oor = |tcdm_add[ADDR_WIDTH-1:OFF_W+IDX_W];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

`ifdef SFM_TCDM_RESP_STALL_EN
  localparam int unsigned SC_W = $clog2(STALL_PERIOD);

  logic [SC_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_q == SC_W'(STALL_PERIOD - 1)) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + SC_W'(1);
    end
  end

  assign stall = (stall_cnt_q == SC_W'(STALL_PERIOD - 1));
`else
  assign stall = 1'b0;
`endif

  assign pop   = !fifo_empty && tcdm_r_ready;
  // A full FIFO can still take a read when its head leaves in the same cycle.
  assign rd_ok = (fifo_count < CNT_W'(RESP_DEPTH)) || (fifo_full && pop);

  assign tcdm_gnt  = tcdm_req && !rst_i && !clear_i && !stall && (!tcdm_wen || rd_ok);
  assign accept    = tcdm_gnt;
  assign wr_accept = accept && !tcdm_wen && !oor;
  assign rd_accept = accept && tcdm_wen;

  assign rd_word = oor ? '0 : mem_q[idx];

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < BE_W; b++) begin
        if (tcdm_be[b]) mem_q[idx][b*8 +: 8] <= tcdm_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      err_q <= 1'b0;
    end else if (accept && oor) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  sfm_tcdm_resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (clear_i),
    .push  (rd_accept),
    .wdata (rd_word),
    .pop   (pop),
    .rdata (tcdm_r_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tcdm_r_valid = !fifo_empty;

endmodule

// File: doc/sfm_tcdm_responder.md
SFM_TCDM_RESPONDER -- requirements
Module: sfm_tcdm_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, TCDM word width in bits (multiple of 32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, storage depth in DATA_WIDTH words (power of 2).
REQ-004 SHALL have parameter RESP_DEPTH, default 4, read-response FIFO depth (>=1).
REQ-005 SHALL have parameter STALL_PERIOD, default 4, grant-stall period in cycles (>=2).
REQ-006 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port clear_i, input, 1, synchronous soft clear.
REQ-009 SHALL have port err_o, output, 1, sticky out-of-range access flag.
REQ-010 SHALL have port tcdm, hci_core_intf.slave, using req, gnt, add, wen (1 = read), be (DATA_WIDTH/8), data, r_data, r_valid, r_ready.

Function
REQ-011 Accept SHALL be req & gnt in a cycle; only accepts change memory or the FIFO.
REQ-012 Word index SHALL be add[log2(DATA_WIDTH/8) +: log2(MEM_WORDS)]; low byte-offset bits ignored.
REQ-013 Out-of-range SHALL be add >= MEM_WORDS*DATA_WIDTH/8: write dropped, read returns all-zero r_data, err_o set on the next edge.
REQ-014 Accepted write SHALL update only bytes with be=1 at the accept edge; writes produce no response.
REQ-015 Accepted read SHALL push the word's current content into the response FIFO at the accept edge; be ignored.
REQ-016 Read latency SHALL be exactly 1 cycle from accept to r_valid when FIFO is empty.
REQ-017 r_valid SHALL equal FIFO not-empty; r_data SHALL be the FIFO head; pop on r_valid & r_ready.
REQ-018 gnt for reads SHALL be high iff FIFO count < RESP_DEPTH, or count == RESP_DEPTH with a pop in the same cycle.
REQ-019 gnt for writes SHALL be high regardless of FIFO occupancy (subject to REQ-028).
REQ-020 gnt SHALL be combinational from req, wen, FIFO state, r_ready and stall state, and low when req is low.
REQ-021 Read accepted the cycle after a write to the same word SHALL return the written data.
REQ-022 Responses SHALL be returned strictly in accept order; r_data held stable while r_valid & !r_ready.
REQ-023 clear_i SHALL flush the FIFO and clear err_o at the next edge; memory contents are kept; an accept coincident with clear_i SHALL be ignored and gnt SHALL be low.

Reset
REQ-024 After rst_i: r_valid=0, FIFO empty, err_o=0, stall counter=0.
REQ-025 Memory contents SHALL NOT be reset; reads of unwritten words are undefined (X allowed).
REQ-026 rst_i mid-burst SHALL discard pending responses; gnt SHALL be 0 while rst_i is high.
REQ-027 rst_i SHALL take priority over clear_i and any accept.

Configuration
REQ-028 With SFM_TCDM_RESP_STALL_EN defined, a free-running counter mod STALL_PERIOD SHALL force gnt=0 in every cycle where counter == STALL_PERIOD-1.
REQ-029 Without SFM_TCDM_RESP_STALL_EN, gnt SHALL depend only on REQ-018..REQ-020, no counter SHALL exist, and STALL_PERIOD SHALL be ignored.

Structure
REQ-030 sfm_pkg SHALL hold the response entry typedef (data word) and a byte-offset-width helper constant.
REQ-031 Response FIFO SHALL be sub-module sfm_tcdm_resp_fifo (push, pop, full, empty, count); memory array and grant logic SHALL be in the top.
REQ-032 Total RTL size SHALL be 120-400 lines.

Verification
REQ-033 Write add=0x10, data=0xDEADBEEF..., be=all-ones, then read add=0x10 next cycle -> r_valid 1 cycle after read accept, r_data=0xDEADBEEF...
REQ-034 Memory 0x00 = all 0x11 bytes, write be=0x0001 data=all 0xAA, read -> byte0=0xAA, bytes1..15=0x11.
REQ-035 r_ready=0, 5 back-to-back reads (RESP_DEPTH=4) -> 4 granted, 5th gnt=0 until r_ready=1; responses emerge in issue order.
REQ-036 Read add=MEM_WORDS*16 -> r_data=0, err_o=1 from next cycle; clear_i pulse -> err_o=0, FIFO empty.
REQ-037 SFM_TCDM_RESP_STALL_EN, STALL_PERIOD=4, req held high -> gnt pattern 1,1,1,0 repeating from reset.
REQ-038 rst_i asserted with 3 responses queued -> next cycle r_valid=0, err_o=0; prior writes still readable.
